// File: rtl/sokoban_move_ctrl.sv
// Box-game move controller: synchronizes the move button, validates walk/push/blocked moves on
// the grid, and commits player/box sprite positions (in pixels) only on a frame-start pulse.
module sokoban_move_ctrl #(
    parameter int unsigned COLS   = 8,
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COL_W  = 3,
    parameter int unsigned ROW_W  = 2,
    parameter int unsigned PIX_W  = 11,
    parameter int unsigned H_ORG  = 100,
    parameter int unsigned H_STEP = 65,
    parameter int unsigned V_ORG  = 100,
    parameter int unsigned V_STEP = 100,
    parameter int unsigned P_COL0 = 0,
    parameter int unsigned P_ROW0 = 2,
    parameter int unsigned B_COL0 = 1,
    parameter int unsigned B_ROW0 = 2,
    parameter int unsigned T_COL  = 5,
    parameter int unsigned T_ROW  = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_btn,
    input  logic             clk_btn,
    input  logic [3:0]       direction,
    input  logic             frame_start,
    output logic [PIX_W-1:0] people_center_h,
    output logic [PIX_W-1:0] people_center_v,
    output logic [PIX_W-1:0] box_center_h,
    output logic [PIX_W-1:0] box_center_v,
    output logic             busy,
    output logic             blocked,
    output logic             win,
    output logic [CNT_W-1:0] move_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam logic [COL_W-1:0] LP_P_COL0 = COL_W'(P_COL0);
    localparam logic [ROW_W-1:0] LP_P_ROW0 = ROW_W'(P_ROW0);
    localparam logic [COL_W-1:0] LP_B_COL0 = COL_W'(B_COL0);
    localparam logic [ROW_W-1:0] LP_B_ROW0 = ROW_W'(B_ROW0);
    localparam logic [COL_W-1:0] LP_T_COL  = COL_W'(T_COL);
    localparam logic [ROW_W-1:0] LP_T_ROW  = ROW_W'(T_ROW);

    localparam int unsigned STEP_W = COL_W + ROW_W + 1;

    // Packed result {out_of_grid, row, col}; the 0 boundary is tested before decrementing.
    function automatic logic [STEP_W-1:0] step_cell(
        input logic [COL_W-1:0] col,
        input logic [ROW_W-1:0] row,
        input logic [3:0]       dir
    );
        logic             oob;
        logic [COL_W-1:0] nc;
        logic [ROW_W-1:0] nr;
        oob = 1'b0;
        nc  = col;
        nr  = row;
        if (dir[3]) begin
            if (row == '0) oob = 1'b1;
            else           nr  = row - ROW_W'(1);
        end else if (dir[2]) begin
            if (32'(row) >= ROWS - 1) oob = 1'b1;
            else                      nr  = row + ROW_W'(1);
        end else if (dir[1]) begin
            if (col == '0) oob = 1'b1;
            else           nc  = col - COL_W'(1);
        end else if (dir[0]) begin
            if (32'(col) >= COLS - 1) oob = 1'b1;
            else                      nc  = col + COL_W'(1);
        end
        return {oob, nr, nc};
    endfunction

    function automatic logic [PIX_W-1:0] pix_h(input logic [COL_W-1:0] col);
        return PIX_W'(H_ORG) + PIX_W'(col) * PIX_W'(H_STEP);
    endfunction

    function automatic logic [PIX_W-1:0] pix_v(input logic [ROW_W-1:0] row);
        return PIX_W'(V_ORG) + PIX_W'(row) * PIX_W'(V_STEP);
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       w_state_d;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic [3:0]       r_dir;
    logic [COL_W-1:0] r_p_col;
    logic [ROW_W-1:0] r_p_row;
    logic [COL_W-1:0] r_b_col;
    logic [ROW_W-1:0] r_b_row;
    logic [COL_W-1:0] r_np_col;
    logic [ROW_W-1:0] r_np_row;
    logic [COL_W-1:0] r_nb_col;
    logic [ROW_W-1:0] r_nb_row;
    logic             r_push;
    logic [PIX_W-1:0] r_ph;
    logic [PIX_W-1:0] r_pv;
    logic [PIX_W-1:0] r_bh;
    logic [PIX_W-1:0] r_bv;
    logic             r_blocked;
    logic             r_win;
    logic [CNT_W-1:0] r_count;

    logic [STEP_W-1:0] w_pstep;
    logic [STEP_W-1:0] w_bstep;
    logic              w_p_oob;
    logic [COL_W-1:0]  w_p_col;
    logic [ROW_W-1:0]  w_p_row;
    logic              w_b_oob;
    logic [COL_W-1:0]  w_b_col;
    logic [ROW_W-1:0]  w_b_row;
    logic              w_hit_box;
    logic              w_dir_ok;
    logic              w_press;
    logic              w_block_now;

    always_comb begin
        w_pstep   = step_cell(r_p_col, r_p_row, r_dir);
        w_bstep   = step_cell(r_b_col, r_b_row, r_dir);
        w_p_oob   = w_pstep[STEP_W-1];
        w_p_row   = w_pstep[COL_W+ROW_W-1:COL_W];
        w_p_col   = w_pstep[COL_W-1:0];
        w_b_oob   = w_bstep[STEP_W-1];
        w_b_row   = w_bstep[COL_W+ROW_W-1:COL_W];
        w_b_col   = w_bstep[COL_W-1:0];
        w_hit_box = (w_p_col == r_b_col) && (w_p_row == r_b_row);
        w_dir_ok  = (r_dir != 4'b0000) && ((r_dir & (r_dir - 4'd1)) == 4'b0000);
        w_press   = r_sync2 && !r_sync3 && (r_state == S_IDLE) && !r_win;
        w_block_now = (r_state == S_CHECK) && w_dir_ok && (w_p_oob || (w_hit_box && w_b_oob));
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_IDLE:   if (w_press) w_state_d = S_CHECK;
            S_CHECK:  w_state_d = (!w_dir_ok || w_block_now) ? S_IDLE : S_WAIT;
            S_WAIT:   if (frame_start) w_state_d = S_COMMIT;
            S_COMMIT: w_state_d = S_IDLE;
            default:  w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_btn) begin
        if (rst_btn) begin
            r_state   <= S_IDLE;
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync3   <= 1'b0;
            r_dir     <= 4'b0000;
            r_p_col   <= LP_P_COL0;
            r_p_row   <= LP_P_ROW0;
            r_b_col   <= LP_B_COL0;
            r_b_row   <= LP_B_ROW0;
            r_np_col  <= LP_P_COL0;
            r_np_row  <= LP_P_ROW0;
            r_nb_col  <= LP_B_COL0;
            r_nb_row  <= LP_B_ROW0;
            r_push    <= 1'b0;
            r_ph      <= pix_h(LP_P_COL0);
            r_pv      <= pix_v(LP_P_ROW0);
            r_bh      <= pix_h(LP_B_COL0);
            r_bv      <= pix_v(LP_B_ROW0);
            r_blocked <= 1'b0;
            r_win     <= 1'b0;
            r_count   <= '0;
        end else begin
            r_sync1   <= clk_btn;
            r_sync2   <= r_sync1;
            r_sync3   <= r_sync2;
            r_state   <= w_state_d;
            r_blocked <= w_block_now;
            if (w_press) r_dir <= direction;
            if (r_state == S_CHECK) begin
                r_np_col <= w_p_col;
                r_np_row <= w_p_row;
                r_nb_col <= w_b_col;
                r_nb_row <= w_b_row;
                r_push   <= w_hit_box;
            end
            if (r_state == S_COMMIT) begin
                r_p_col <= r_np_col;
                r_p_row <= r_np_row;
                r_ph    <= pix_h(r_np_col);
                r_pv    <= pix_v(r_np_row);
                if (r_push) begin
                    r_b_col <= r_nb_col;
                    r_b_row <= r_nb_row;
                    r_bh    <= pix_h(r_nb_col);
                    r_bv    <= pix_v(r_nb_row);
                end
                if (r_count != '1) r_count <= r_count + CNT_W'(1);
            end
            if ((r_b_col == LP_T_COL) && (r_b_row == LP_T_ROW)) r_win <= 1'b1;
        end
    end

    always_comb begin
        people_center_h = r_ph;
        people_center_v = r_pv;
        box_center_h    = r_bh;
        box_center_v    = r_bv;
        busy            = (r_state != S_IDLE);
        blocked         = r_blocked;
        win             = r_win;
        move_count      = r_count;
    end

endmodule

// File: tb/tb_sokoban_move_ctrl.sv
// Directed bench for sokoban_move_ctrl: expected values are queued at stimulus time and
// popped when the DUT outputs are sampled on the falling clock edge.
module tb_sokoban_move_ctrl;

    logic        clk;
    logic        rst_btn;
    logic        clk_btn;
    logic [3:0]  direction;
    logic        frame_start;
    logic [10:0] ph;
    logic [10:0] pv;
    logic [10:0] bh;
    logic [10:0] bv;
    logic        busy;
    logic        blocked;
    logic        win;
    logic [7:0]  move_count;

    logic [31:0] exp_q[$];
    int          n_cmp;
    int          n_err;
    int          blk_cnt;
    int          busy_cnt;
    logic        all_busy;
    logic        unchanged;

    localparam logic [3:0] D_UP    = 4'b1000;
    localparam logic [3:0] D_LEFT  = 4'b0010;
    localparam logic [3:0] D_RIGHT = 4'b0001;

    sokoban_move_ctrl dut (
        .clk             (clk),
        .rst_btn         (rst_btn),
        .clk_btn         (clk_btn),
        .direction       (direction),
        .frame_start     (frame_start),
        .people_center_h (ph),
        .people_center_v (pv),
        .box_center_h    (bh),
        .box_center_v    (bv),
        .busy            (busy),
        .blocked         (blocked),
        .win             (win),
        .move_count      (move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, observed %0d", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
            end
        end
    endtask

    task automatic do_reset();
        rst_btn     = 1'b1;
        clk_btn     = 1'b0;
        direction   = 4'b0000;
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_btn = 1'b0;
        @(negedge clk);
    endtask

    // Ten falling-edge samples; the button is released half way through.
    task automatic press(input logic [3:0] dir, output int blk, output int bsy);
        blk       = 0;
        bsy       = 0;
        direction = dir;
        clk_btn   = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (blocked) blk++;
            if (busy) bsy++;
            if (i == 5) clk_btn = 1'b0;
        end
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic chk_pos(input string tag, input int eph, input int ebh, input int ecnt);
        expect_val(32'(eph));  chk({tag, "_ph"}, 32'(ph));
        expect_val(300);       chk({tag, "_pv"}, 32'(pv));
        expect_val(32'(ebh));  chk({tag, "_bh"}, 32'(bh));
        expect_val(300);       chk({tag, "_bv"}, 32'(bv));
        expect_val(32'(ecnt)); chk({tag, "_cnt"}, 32'(move_count));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset values, sampled while reset is held and after release
        rst_btn = 1'b1; clk_btn = 1'b0; direction = 4'b0000; frame_start = 1'b0;
        repeat (2) @(negedge clk);
        expect_val(100); chk("rst_held_ph", 32'(ph));
        expect_val(165); chk("rst_held_bh", 32'(bh));
        do_reset();
        chk_pos("rst", 100, 165, 0);
        expect_val(0); chk("rst_win", 32'(win));
        expect_val(0); chk("rst_busy", 32'(busy));
        expect_val(0); chk("rst_blocked", 32'(blocked));

        // Push right, frame 50 cycles later
        press(D_RIGHT, blk_cnt, busy_cnt);
        expect_val(0); chk("push_blk", 32'(blk_cnt));
        expect_val(8); chk("push_busy_cycles", 32'(busy_cnt));
        all_busy  = 1'b1;
        unchanged = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) all_busy = 1'b0;
            if (ph != 11'd100 || bh != 11'd165 || move_count != 8'd0) unchanged = 1'b0;
        end
        expect_val(1); chk("push_busy_wait", 32'(all_busy));
        expect_val(1); chk("push_hold_pos", 32'(unchanged));
        frame();
        chk_pos("push", 165, 230, 1);
        expect_val(0); chk("push_busy_after", 32'(busy));

        // Left from column 0 is blocked without waiting for a frame
        do_reset();
        press(D_LEFT, blk_cnt, busy_cnt);
        expect_val(1); chk("left_blk_pulse", 32'(blk_cnt));
        expect_val(1); chk("left_busy_cycles", 32'(busy_cnt));
        chk_pos("left", 100, 165, 0);

        // Up is legal from row 2 and has no frame yet; abort it via reset
        press(D_UP, blk_cnt, busy_cnt);
        expect_val(0); chk("up_blk", 32'(blk_cnt));
        expect_val(1); chk("up_busy", 32'(busy));

        // Non-one-hot direction, then a dropped second press while busy
        do_reset();
        press(4'b1010, blk_cnt, busy_cnt);
        expect_val(0); chk("bad_dir_blk", 32'(blk_cnt));
        expect_val(1); chk("bad_dir_busy_cycles", 32'(busy_cnt));
        chk_pos("bad_dir", 100, 165, 0);
        press(D_RIGHT, blk_cnt, busy_cnt);
        press(D_LEFT, blk_cnt, busy_cnt);
        expect_val(0); chk("second_press_blk", 32'(blk_cnt));
        frame();
        chk_pos("second_press", 165, 230, 1);

        // Four pushes reach the target; fifth press ignored
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            press(D_RIGHT, blk_cnt, busy_cnt);
            frame();
            if (k == 3) begin
                expect_val(0); chk("win_early", 32'(win));
            end
        end
        chk_pos("win", 360, 425, 4);
        expect_val(1); chk("win_set", 32'(win));
        press(D_RIGHT, blk_cnt, busy_cnt);
        expect_val(0); chk("win_press_busy", 32'(busy_cnt));
        frame();
        chk_pos("win_ignored", 360, 425, 4);
        expect_val(1); chk("win_sticky", 32'(win));

        // Reset during WAIT_FRAME aborts the move
        do_reset();
        press(D_RIGHT, blk_cnt, busy_cnt);
        expect_val(1); chk("abort_busy_before", 32'(busy));
        rst_btn = 1'b1;
        #1;
        expect_val(0);   chk("abort_busy_now", 32'(busy));
        expect_val(100); chk("abort_ph_now", 32'(ph));
        expect_val(0);   chk("abort_win_now", 32'(win));
        @(negedge clk);
        rst_btn = 1'b0;
        @(negedge clk);
        frame();
        chk_pos("abort", 100, 165, 0);
        expect_val(0); chk("abort_busy_after", 32'(busy));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
